// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, state encoding and access-width decode for the byte-serial LSU
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

  // Zero marks an illegal funct3, which bypasses memory entirely.
  function automatic logic [2:0] width_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      F3_W:        return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of assembled little-endian load data
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  always_comb begin
    data_out = data_in;
    case (funct3)
      F3_B:    data_out = {{24{data_in[7]}}, data_in[7:0]};
      F3_H:    data_out = {{16{data_in[15]}}, data_in[15:0]};
      F3_BU:   data_out = {24'd0, data_in[7:0]};
      F3_HU:   data_out = {16'd0, data_in[15:0]};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/byte_serial_lsu.sv
// rtl/byte_serial_lsu.sv - RV32 load/store initiator issuing 1/2/4 sequential byte accesses to a byte-wide memory
module byte_serial_lsu
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [BYTE_WIDTH-1:0]    mem_wdata,
  input  logic [BYTE_WIDTH-1:0]    mem_rdata
);

  lsu_state_t               state_q, state_d;
  logic                     write_q, write_d;
  logic                     err_q, err_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [2:0]               n_q, n_d;
  logic [1:0]               k_q, k_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;

  logic [ADDRESS_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0]    wdata_shifted;
  logic [DATA_WIDTH-1:0]    rdata_lane;
  logic [DATA_WIDTH-1:0]    ext_data;
  logic                     last_byte;

  load_extend u_load_extend (
    .funct3   (funct3_q),
    .data_in  (data_q),
    .data_out (ext_data)
  );

  assign cur_addr      = addr_q + ADDRESS_WIDTH'(k_q);
  assign wdata_shifted = wdata_q >> {k_q, 3'b000};
  assign rdata_lane    = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, mem_rdata} << {k_q, 3'b000};
  assign last_byte     = ({1'b0, k_q} == (n_q - 3'd1));

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    err_d       = err_q;
    funct3_d    = funct3_q;
    n_d         = n_q;
    k_d         = k_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          n_d      = width_bytes(req_funct3);
          err_d    = (width_bytes(req_funct3) == 3'd0);
          k_d      = 2'd0;
          data_d   = '0;
          state_d  = (width_bytes(req_funct3) == 3'd0) ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        last_addr_d = cur_addr;
        // data_q is cleared on accept, so OR-ing each lane in assembles the word.
        if (!write_q) data_d = data_q | rdata_lane;
        if (last_byte) state_d = RESP;
        else           k_d     = k_q + 2'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      funct3_q    <= 3'd0;
      n_q         <= 3'd0;
      k_q         <= 2'd0;
      addr_q      <= '0;
      last_addr_q <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      err_q       <= err_d;
      funct3_q    <= funct3_d;
      n_q         <= n_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
    end
  end

  // Outputs decode straight from state so an async reset quiets the memory port at once.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_err   = (state_q == RESP) && err_q;
    rsp_rdata = ((state_q == RESP) && !write_q && !err_q) ? ext_data : '0;
    mem_we    = (state_q == ACCESS) && write_q;
    mem_wdata = ((state_q == ACCESS) && write_q) ? wdata_shifted[BYTE_WIDTH-1:0] : '0;
    mem_addr  = (state_q == ACCESS) ? cur_addr : last_addr_q;
  end

endmodule

// File: tb/tb_byte_serial_lsu.sv
// tb/tb_byte_serial_lsu.sv - scoreboard bench for byte_serial_lsu with a behavioural byte memory
module tb_byte_serial_lsu;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem [1024];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [7:0]  pre_data = '0;

  rsp_t        exp_q[$];
  logic [31:0] last_addr;
  int          n_checks = 0;
  int          n_fails  = 0;

  always #5 clk = ~clk;

  byte_serial_lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (pre_we)      mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end else begin
        check("idle_rdata", rsp_rdata, 32'd0);
        check("idle_err", 32'(rsp_err), 32'd0);
      end
    end
  end

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input logic hold);
    int   n;
    rsp_t e;
    n = (f3 == 3'b000 || f3 == 3'b100) ? 1 :
        (f3 == 3'b001 || f3 == 3'b101) ? 2 :
        (f3 == 3'b010) ? 4 : 0;
    @(negedge clk);
    check("req_ready_before", 32'(req_ready), 32'd1);
    req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    e.rdata = exp_rdata; e.err = exp_err;
    exp_q.push_back(e);
    #1;
    if (!hold) req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("mem_we", 32'(mem_we), 32'(wr));
      check("mem_addr", mem_addr, addr + 32'(i));
      check("mem_wdata", 32'(mem_wdata), wr ? 32'(wdata[8*i +: 8]) : 32'd0);
      if (hold) check("req_ready_busy", 32'(req_ready), 32'd0);
    end
    if (n == 0) begin
      @(negedge clk);
      check("err_no_we", 32'(mem_we), 32'd0);
      check("err_addr_held", mem_addr, last_addr);
    end else begin
      last_addr = addr + 32'(n - 1);
      @(negedge clk);
    end
    if (hold) check("req_ready_resp", 32'(req_ready), 32'd0);
    #1;
    check("rsp_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    req_valid = 1'b0;
    @(negedge clk);
    check("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    last_addr = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;

    preload(10'h3FE, 8'h11);
    preload(10'h3FF, 8'h22);
    preload(10'h000, 8'h33);
    preload(10'h001, 8'h44);
    for (int i = 0; i < 4; i++) preload(10'h200 + 10'(i), 8'h5A);

    run_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    run_req(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    run_req(1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFFDE, 1'b0, 1'b0);
    run_req(1'b0, 3'b100, 32'h103, 32'h0, 32'h000000DE, 1'b0, 1'b0);
    run_req(1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFFDEAD, 1'b0, 1'b0);
    run_req(1'b0, 3'b101, 32'h102, 32'h0, 32'h0000DEAD, 1'b0, 1'b0);
    run_req(1'b0, 3'b001, 32'h101, 32'h0, 32'hFFFFADBE, 1'b0, 1'b0);
    run_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h44332211, 1'b0, 1'b0);
    run_req(1'b0, 3'b011, 32'h300, 32'h0, 32'h0, 1'b1, 1'b0);
    run_req(1'b1, 3'b011, 32'h300, 32'h12345678, 32'h0, 1'b1, 1'b0);
    run_req(1'b0, 3'b111, 32'h304, 32'h0, 32'h0, 1'b1, 1'b0);
    run_req(1'b1, 3'b001, 32'h380, 32'h0000BEEF, 32'h0, 1'b0, 1'b0);
    check("sh_byte0", 32'(mem[10'h380]), 32'h000000EF);
    check("sh_byte1", 32'(mem[10'h381]), 32'h000000BE);

    @(negedge clk);
    req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'h04030201;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_test_we", 32'(mem_we), 32'd1);
    check("rst_test_wdata", 32'(mem_wdata), 32'h01);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_rsp_valid_later", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    last_addr = 32'd0;
    check("mem_200", 32'(mem[10'h200]), 32'h01);
    check("mem_202", 32'(mem[10'h202]), 32'h5A);
    check("mem_203", 32'(mem[10'h203]), 32'h5A);

    run_req(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/byte_serial_lsu.md
Name: byte_serial_lsu

Overview:
- Load/store initiator for the byte-wide data memory (8-bit read/write data, asynchronous read, write on posedge clk).
- Accepts one RV32 load/store request from the execute stage and issues 1, 2 or 4 sequential byte accesses, little-endian.
- Assembles load data with sign/zero extension and returns it on a one-cycle response pulse.
- Sits between the pipeline's memory stage and the data memory.

Parameters:
- ADDRESS_WIDTH, 32, byte address width of request and memory port.
- DATA_WIDTH, 32, register/word width of request and response data.
- BYTE_WIDTH, 8, memory data width; fixed at 8.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE; accept = req_valid && req_ready.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  ADDRESS_WIDTH  base byte address; misalignment allowed.
- req_wdata  input  DATA_WIDTH  store data, low bytes used.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err  output  1  illegal funct3, qualified by rsp_valid.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDRESS_WIDTH  memory byte address.
- mem_wdata  output  BYTE_WIDTH  memory write byte.
- mem_rdata  input  BYTE_WIDTH  memory read byte, combinational from mem_addr.

Behaviour:
- Reset (async, rst_n low): state IDLE, byte counter 0, data register 0.
  - Outputs: req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, mem_we 0, mem_addr 0, mem_wdata 0.
  - mem_we is decoded from state, so it deasserts in the same cycle reset asserts.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - On accept, latch write, funct3, addr and wdata.
  - Set N = 1 for B/BU, 2 for H/HU, 4 for W; k = 0.
  - Go to ACCESS, or to RESP with the error flag set when funct3 is 011, 110 or 111.
  - req_valid while not in IDLE is ignored, with no queueing.
- ACCESS, byte k:
  - mem_addr = addr + k, modulo 2^ADDRESS_WIDTH (wraps at top of space).
  - Store: mem_we = 1, mem_wdata = wdata[8k+7:8k].
  - Load: mem_we = 0, mem_wdata = 0, and mem_rdata is captured into data[8k+7:8k] at the edge.
  - k increments each cycle; after byte N-1, go to RESP.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE.
  - Load: rsp_rdata is the extended assembled value.
  - Store or error: rsp_rdata = 0.
  - rsp_err = 1 only for an illegal funct3; an error issues no memory access.
- Outside RESP: rsp_valid = 0 and rsp_rdata/rsp_err are held at 0.
- Extension:
  - B: sign-extend bit 7.
  - H: sign-extend bit 15.
  - BU/HU: zero-extend.
  - W: pass through.
- Latency, with accept in cycle 0:
  - Byte accesses occur in cycles 1..N, and rsp_valid is in cycle N+1.
  - An illegal request responds in cycle 1.
  - The next accept is possible in cycle N+2, so throughput is one request per N+2 cycles.
- Outside ACCESS: mem_addr holds its last value and mem_we = 0.
- Reset mid-operation: the transaction is abandoned with no response. Bytes already written stay written; the remaining bytes are never written.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum lsu_state_t {IDLE, ACCESS, RESP}.
  - Function width_bytes(funct3) returning 1/2/4, or 0 for illegal.
- Sub-module load_extend:
  - Combinational, inputs funct3 and the 32-bit assembled data, output the extended 32-bit value.
  - Instanced once.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF -> cycles 1-4: mem_we = 1, mem_addr 0x100..0x103, mem_wdata EF, BE, AD, DE. Cycle 5: rsp_valid = 1, rsp_err = 0, rsp_rdata = 0.
- LW 0x100 after the above -> mem_we = 0 throughout; cycle 5: rsp_rdata = 0xDEADBEEF. req_valid held high during cycles 1-5 is not accepted until cycle 6.
- Byte and half loads at 0x103 / 0x102:
  - LB 0x103 -> 0xFFFFFFDE in cycle 2.
  - LBU 0x103 -> 0x000000DE.
  - LH 0x102 -> 0xFFFFDEAD in cycle 3.
  - LHU 0x102 -> 0x0000DEAD.
  - LH 0x101 (misaligned) -> 0xFFFFADBE.
- LW at 0xFFFFFFFE with memory preloaded 11, 22 at FFFFFFFE/F and 33, 44 at 0/1 -> mem_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; rsp_rdata = 0x44332211.
- Illegal funct3 011, load and store -> no mem_we and mem_addr unchanged; cycle 1: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; req_ready is back in cycle 2.
- SW 0x200, wdata 0x04030201, with rst_n pulled low mid-cycle 2 -> mem_we drops immediately and all outputs take reset values with no rsp_valid. Memory shows 0x200 = 01 and 0x201 = 02 (if the edge preceded reset); 0x202/0x203 stay unwritten. After rst_n rises, req_ready = 1 and a fresh LW completes normally.
